uart_in_source: RTL and testbench

Simulation-side character source for the SoC UART input port, the receive-direction counterpart of the testbench's UART output printer. Host logic or DPI glue pushes bytes into a DEPTH-entry FIFO. The block answers each DUT read request (`uart_in_valid`) with the FIFO head, or `8'hff` when it has nothing to deliver. It sits in the testbench top beside `SimTop` and drives `io_uart_in_ch` in place of the constant `8'hff` tie-off.

---
 rtl/uart_in_source.sv | 163 ++++++++++++++++
 tb/tb_uart_in_source.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_in_source.sv
// uart_in_source: simulation-side byte source for the SoC UART input port.
// The host pushes bytes into a DEPTH-entry circular FIFO. Each DUT read
// request (uart_in_valid) consumes the FIFO head in the same cycle, or sees
// 8'hff when nothing is deliverable. A two-state pacing FSM enforces at least
// GAP_CYCLES idle cycles between consecutive deliveries.
//
// Ports:
//   clock, reset_n             - single clock, async active-low reset
//   push_valid/push_ch/push_ready - host enqueue handshake (ready = not full)
//   uart_in_valid              - DUT read request, one byte per high cycle
//   uart_in_ch                 - response byte (head or 8'hff)
//   level                      - FIFO occupancy
//   delivered_cnt              - bytes delivered, wraps modulo 2^32
//   echo_valid/echo_ch         - delivered-byte echo
//
// Optional feature: define UART_IN_SOURCE_ECHO_EN to build the echo
// registers; otherwise echo_valid/echo_ch are tied to 0.
module uart_in_source #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_valid,
  input  logic [7:0]               push_ch,
  output logic                     push_ready,
  input  logic                     uart_in_valid,
  output logic [7:0]               uart_in_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              delivered_cnt,
  output logic                     echo_valid,
  output logic [7:0]               echo_ch
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_GAP   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];

  logic               empty;
  logic               full;
  logic               deliverable;
  logic               push_fire;
  logic               pop_fire;
  logic [7:0]         head;

  // Status derived from registered pointers only.
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
    deliverable = (state_q == ST_READY) && !empty;
    head        = mem_q[rd_ptr_q[AW-1:0]];
    push_fire   = push_valid && !full;
    pop_fire    = uart_in_valid && deliverable;
  end

  assign push_ready    = !full;
  assign uart_in_ch    = deliverable ? head : 8'hff;
  assign level         = wr_ptr_q - rd_ptr_q;
  assign delivered_cnt = cnt_q;

  // Pacing FSM: GAP lasts exactly GAP_CYCLES cycles after each delivery.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_READY: begin
        if (pop_fire && (GAP_CYCLES != 0)) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_READY;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d   = ST_READY;
        gap_cnt_d = '0;
      end
    endcase
  end

  // FIFO pointers, storage and delivery counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_fire);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_fire);
    cnt_d    = cnt_q + 32'(pop_fire);
    mem_d    = mem_q;
    if (push_fire) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_ch;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_READY;
      gap_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: pointers alone define valid contents.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef UART_IN_SOURCE_ECHO_EN
  logic       echo_valid_q, echo_valid_d;
  logic [7:0] echo_ch_q, echo_ch_d;

  // One-cycle strobe after each delivery; byte held until the next one.
  always_comb begin
    echo_valid_d = pop_fire;
    echo_ch_d    = echo_ch_q;
    if (pop_fire) begin
      echo_ch_d = head;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_valid_q <= 1'b0;
      echo_ch_q    <= 8'h00;
    end else begin
      echo_valid_q <= echo_valid_d;
      echo_ch_q    <= echo_ch_d;
    end
  end

  assign echo_valid = echo_valid_q;
  assign echo_ch    = echo_ch_q;
`else
  assign echo_valid = 1'b0;
  assign echo_ch    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_in_source.sv
// Directed testbench for uart_in_source: one instance with GAP_CYCLES = 0
// (u_dut0) and one with GAP_CYCLES = 3 (u_dut3), both DEPTH = 16.
module tb_uart_in_source;

`ifdef UART_IN_SOURCE_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;

  logic        push_valid0, push_ready0, uart_in_valid0, echo_valid0;
  logic [7:0]  push_ch0, uart_in_ch0, echo_ch0;
  logic [4:0]  level0;
  logic [31:0] delivered_cnt0;

  logic        push_valid3, push_ready3, uart_in_valid3, echo_valid3;
  logic [7:0]  push_ch3, uart_in_ch3, echo_ch3;
  logic [4:0]  level3;
  logic [31:0] delivered_cnt3;

  int vectors;
  int miscompares;

  uart_in_source #(.DEPTH(16), .GAP_CYCLES(0)) u_dut0 (
    .clock         (clock),
    .reset_n       (reset_n),
    .push_valid    (push_valid0),
    .push_ch       (push_ch0),
    .push_ready    (push_ready0),
    .uart_in_valid (uart_in_valid0),
    .uart_in_ch    (uart_in_ch0),
    .level         (level0),
    .delivered_cnt (delivered_cnt0),
    .echo_valid    (echo_valid0),
    .echo_ch       (echo_ch0)
  );

  uart_in_source #(.DEPTH(16), .GAP_CYCLES(3)) u_dut3 (
    .clock         (clock),
    .reset_n       (reset_n),
    .push_valid    (push_valid3),
    .push_ch       (push_ch3),
    .push_ready    (push_ready3),
    .uart_in_valid (uart_in_valid3),
    .uart_in_ch    (uart_in_ch3),
    .level         (level3),
    .delivered_cnt (delivered_cnt3),
    .echo_valid    (echo_valid3),
    .echo_ch       (echo_ch3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    push_valid0 = 1'b0; push_ch0 = 8'h00; uart_in_valid0 = 1'b0;
    push_valid3 = 1'b0; push_ch3 = 8'h00; uart_in_valid3 = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (push_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_push_ready got %b want 1", push_ready0); end
    vectors++;
    if (uart_in_ch0 !== 8'hff) begin miscompares++; $display("FAIL reset_ch got %h want ff", uart_in_ch0); end
    vectors++;
    if (level0 !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level0); end
    vectors++;
    if (delivered_cnt0 !== 32'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", delivered_cnt0); end
    vectors++;
    if (echo_valid0 !== 1'b0 || echo_ch0 !== 8'h00) begin
      miscompares++; $display("FAIL reset_echo got %b/%h want 0/00", echo_valid0, echo_ch0);
    end
    vectors++;
    if (uart_in_ch3 !== 8'hff || push_ready3 !== 1'b1 || level3 !== 5'd0) begin
      miscompares++; $display("FAIL reset_dut3 got ch %h rdy %b lvl %0d want ff 1 0", uart_in_ch3, push_ready3, level3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ch [4];
    exp_ch = '{8'h41, 8'h42, 8'h43, 8'hff};
    push_valid0 = 1'b1;
    push_ch0 = 8'h41; tick();
    push_ch0 = 8'h42; tick();
    push_ch0 = 8'h43; tick();
    push_valid0 = 1'b0;
    uart_in_valid0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (uart_in_ch0 !== exp_ch[i]) begin
        miscompares++; $display("FAIL b2b_ch[%0d] got %h want %h", i, uart_in_ch0, exp_ch[i]);
      end
      tick();
    end
    uart_in_valid0 = 1'b0;
    vectors++;
    if (delivered_cnt0 !== 32'd3) begin miscompares++; $display("FAIL b2b_cnt got %0d want 3", delivered_cnt0); end
    vectors++;
    if (level0 !== 5'd0) begin miscompares++; $display("FAIL b2b_level got %0d want 0", level0); end
  endtask

  task automatic test_full();
    push_valid0 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_ch0 = 8'(i);
      tick();
    end
    push_valid0 = 1'b0;
    vectors++;
    if (level0 !== 5'd16) begin miscompares++; $display("FAIL full_level got %0d want 16", level0); end
    vectors++;
    if (push_ready0 !== 1'b0) begin miscompares++; $display("FAIL full_push_ready got %b want 0", push_ready0); end
    // Push while full, with a simultaneous pop: push must be rejected.
    push_valid0 = 1'b1; push_ch0 = 8'h55; uart_in_valid0 = 1'b1;
    vectors++;
    if (uart_in_ch0 !== 8'h00) begin miscompares++; $display("FAIL full_pop_ch got %h want 00", uart_in_ch0); end
    tick();
    push_valid0 = 1'b0;
    vectors++;
    if (level0 !== 5'd15) begin miscompares++; $display("FAIL full_pop_level got %0d want 15", level0); end
    for (int i = 1; i < 16; i++) begin
      vectors++;
      if (uart_in_ch0 !== 8'(i)) begin
        miscompares++; $display("FAIL drain_ch[%0d] got %h want %h", i, uart_in_ch0, 8'(i));
      end
      tick();
    end
    uart_in_valid0 = 1'b0;
    vectors++;
    if (level0 !== 5'd0 || uart_in_ch0 !== 8'hff) begin
      miscompares++; $display("FAIL drain_end got lvl %0d ch %h want 0 ff", level0, uart_in_ch0);
    end
    vectors++;
    if (delivered_cnt0 !== 32'd19) begin miscompares++; $display("FAIL full_cnt got %0d want 19", delivered_cnt0); end
  endtask

  task automatic test_pacing();
    logic [7:0] exp_ch [5];
    exp_ch = '{8'h61, 8'hff, 8'hff, 8'hff, 8'h62};
    push_valid3 = 1'b1;
    push_ch3 = 8'h61; tick();
    push_ch3 = 8'h62; tick();
    push_valid3 = 1'b0;
    uart_in_valid3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (uart_in_ch3 !== exp_ch[i]) begin
        miscompares++; $display("FAIL pace_ch[t+%0d] got %h want %h", i, uart_in_ch3, exp_ch[i]);
      end
      tick();
    end
    uart_in_valid3 = 1'b0;
    vectors++;
    if (delivered_cnt3 !== 32'd2) begin miscompares++; $display("FAIL pace_cnt got %0d want 2", delivered_cnt3); end
    vectors++;
    if (level3 !== 5'd0) begin miscompares++; $display("FAIL pace_level got %0d want 0", level3); end
  endtask

  task automatic test_empty_race();
    push_valid0 = 1'b1; push_ch0 = 8'h7a; uart_in_valid0 = 1'b1;
    vectors++;
    if (uart_in_ch0 !== 8'hff) begin miscompares++; $display("FAIL race_ch got %h want ff", uart_in_ch0); end
    tick();
    push_valid0 = 1'b0;
    vectors++;
    if (delivered_cnt0 !== 32'd19 || level0 !== 5'd1) begin
      miscompares++; $display("FAIL race_state got cnt %0d lvl %0d want 19 1", delivered_cnt0, level0);
    end
    vectors++;
    if (uart_in_ch0 !== 8'h7a) begin miscompares++; $display("FAIL race_next_ch got %h want 7a", uart_in_ch0); end
    tick();
    uart_in_valid0 = 1'b0;
    vectors++;
    if (delivered_cnt0 !== 32'd20 || level0 !== 5'd0) begin
      miscompares++; $display("FAIL race_after got cnt %0d lvl %0d want 20 0", delivered_cnt0, level0);
    end
  endtask

  task automatic test_echo();
    logic [7:0] exp_ech;
    exp_ech = ECHO_EN ? 8'h31 : 8'h00;
    push_valid0 = 1'b1; push_ch0 = 8'h31; tick();
    push_valid0 = 1'b0;
    uart_in_valid0 = 1'b1;
    vectors++;
    if (echo_valid0 !== 1'b0) begin miscompares++; $display("FAIL echo_t_valid got %b want 0", echo_valid0); end
    tick();
    uart_in_valid0 = 1'b0;
    vectors++;
    if (echo_valid0 !== ECHO_EN || echo_ch0 !== exp_ech) begin
      miscompares++; $display("FAIL echo_t1 got %b/%h want %b/%h", echo_valid0, echo_ch0, ECHO_EN, exp_ech);
    end
    tick();
    vectors++;
    if (echo_valid0 !== 1'b0 || echo_ch0 !== exp_ech) begin
      miscompares++; $display("FAIL echo_t2 got %b/%h want 0/%h", echo_valid0, echo_ch0, exp_ech);
    end
  endtask

  task automatic test_async_reset();
    push_valid0 = 1'b1; push_ch0 = 8'h99;
    push_valid3 = 1'b1; push_ch3 = 8'h98;
    tick();
    push_valid0 = 1'b0; push_valid3 = 1'b0;
    vectors++;
    if (level0 !== 5'd1 || delivered_cnt0 !== 32'd21) begin
      miscompares++; $display("FAIL pre_areset got lvl %0d cnt %0d want 1 21", level0, delivered_cnt0);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (level0 !== 5'd0 || push_ready0 !== 1'b1 || uart_in_ch0 !== 8'hff || delivered_cnt0 !== 32'd0) begin
      miscompares++; $display("FAIL areset_dut0 got lvl %0d rdy %b ch %h cnt %0d want 0 1 ff 0",
                              level0, push_ready0, uart_in_ch0, delivered_cnt0);
    end
    vectors++;
    if (level3 !== 5'd0 || uart_in_ch3 !== 8'hff || delivered_cnt3 !== 32'd0) begin
      miscompares++; $display("FAIL areset_dut3 got lvl %0d ch %h cnt %0d want 0 ff 0",
                              level3, uart_in_ch3, delivered_cnt3);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_full();
    test_pacing();
    test_empty_race();
    test_echo();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
